// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the FPU arbiter slice.
//   state_t      : arbiter FSM states
//   OP_*         : 5-bit alu_control encodings of the FP operations
//   FPU_*        : one-hot opcodes understood by fpu_top
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [4:0] OP_FADD  = 5'b10000;
  localparam logic [4:0] OP_FSUB  = 5'b10001;
  localparam logic [4:0] OP_FMUL  = 5'b10010;
  localparam logic [4:0] OP_FDIV  = 5'b10011;
  localparam logic [4:0] OP_FCMP  = 5'b11011;
  localparam logic [4:0] OP_FMIN  = 5'b10110;
  localparam logic [4:0] OP_FMAX  = 5'b10111;
  localparam logic [4:0] OP_FSQRT = 5'b10101;

  localparam logic [7:0] FPU_ADD  = 8'h01;
  localparam logic [7:0] FPU_SUB  = 8'h02;
  localparam logic [7:0] FPU_MUL  = 8'h04;
  localparam logic [7:0] FPU_DIV  = 8'h08;
  localparam logic [7:0] FPU_CMP  = 8'h10;
  localparam logic [7:0] FPU_MIN  = 8'h20;
  localparam logic [7:0] FPU_MAX  = 8'h40;
  localparam logic [7:0] FPU_SQRT = 8'h80;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational decode of the 5-bit alu_control op into the fpu_top one-hot
// opcode.
//   op     : alu_control op (bit4 set for FP ops)
//   legal  : op maps to an FPU operation
//   opcode : one-hot FPU opcode, zero when the op is illegal
module fpu_op_decode
  import fpu_arb_pkg::*;
(
  input  logic [4:0] op,
  output logic       legal,
  output logic [7:0] opcode
);

  always_comb begin
    legal  = 1'b1;
    opcode = '0;
    case (op)
      OP_FADD:  opcode = FPU_ADD;
      OP_FSUB:  opcode = FPU_SUB;
      OP_FMUL:  opcode = FPU_MUL;
      OP_FDIV:  opcode = FPU_DIV;
      OP_FCMP:  opcode = FPU_CMP;
      OP_FMIN:  opcode = FPU_MIN;
      OP_FMAX:  opcode = FPU_MAX;
      OP_FSQRT: opcode = FPU_SQRT;
      default:  legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Two-port round-robin arbiter in front of a single multi-cycle fpu_top.
// One operation in flight at a time: accept, pulse the opcode for one cycle,
// wait for out_valid (bounded by TIMEOUT), then hold the result until the
// owning port takes it.
//   clk, rstn                : clock, asynchronous active-low reset
//   reqN_valid/op/a/b/ready  : request handshake for port N (0 = EX stage)
//   rspN_valid/data/ready    : response handshake for port N
//   fpu_opcode, fpu_x1/x2    : one-hot opcode pulse and operands to fpu_top
//   fpu_y, fpu_out_valid     : result and result strobe from fpu_top
//   busy                     : arbiter not idle
//   timeout_err              : sticky, set when a WAIT times out
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  input  logic [4:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic [7:0]        fpu_opcode,
  output logic [DATA_W-1:0] fpu_x1,
  output logic [DATA_W-1:0] fpu_x2,
  input  logic [DATA_W-1:0] fpu_y,
  input  logic              fpu_out_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t              state, state_nxt;
  logic                owner;
  logic                last_grant;
  logic [4:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q, result;
  logic [CNT_W-1:0]    wait_cnt;
  logic                grant0, grant1, accept, rsp_taken, timeout_hit;
  logic                legal;
  logic [7:0]          dec_opcode;

  fpu_op_decode u_decode (
    .op     (op_q),
    .legal  (legal),
    .opcode (dec_opcode)
  );

  // Lone requester wins; on contention the port that was not served last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  assign req0_ready  = (state == IDLE) & grant0;
  assign req1_ready  = (state == IDLE) & grant1;
  assign accept      = req0_ready | req1_ready;
  assign rsp_taken   = owner ? rsp1_ready : rsp0_ready;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Operands go straight from the request latches so they are valid with
  // the opcode pulse.
  assign fpu_x1 = a_q;
  assign fpu_x2 = b_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = legal ? WAIT : HOLD;
      WAIT:    if (fpu_out_valid || timeout_hit) state_nxt = HOLD;
      HOLD:    if (rsp_taken) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    fpu_opcode = (state == ISSUE) ? dec_opcode : '0;
    rsp0_valid = (state == HOLD) & ~owner;
    rsp1_valid = (state == HOLD) & owner;
    rsp0_data  = rsp0_valid ? result : '0;
    rsp1_data  = rsp1_valid ? result : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant1;
            op_q  <= grant1 ? req1_op : req0_op;
            a_q   <= grant1 ? req1_a  : req0_a;
            b_q   <= grant1 ? req1_b  : req0_b;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          if (!legal) result <= '0;
        end
        WAIT: begin
          // A result arriving on the timeout cycle still counts as success.
          if (fpu_out_valid) begin
            result <= fpu_y;
          end else if (timeout_hit) begin
            result      <= '0;
            timeout_err <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (rsp_taken) last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
module tb_fpu_arbiter;

  localparam int unsigned DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          r_valid [2];
  logic [4:0]    r_op    [2];
  logic [DW-1:0] r_a     [2];
  logic [DW-1:0] r_b     [2];
  int            r_lat   [2];
  logic          rsp_rdy [2];

  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]    req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [7:0]    fpu_opcode;
  logic [DW-1:0] fpu_x1, fpu_x2, fpu_y;
  logic          fpu_out_valid, busy, timeout_err;

  assign req0_valid = r_valid[0];
  assign req0_op    = r_op[0];
  assign req0_a     = r_a[0];
  assign req0_b     = r_b[0];
  assign rsp0_ready = rsp_rdy[0];
  assign req1_valid = r_valid[1];
  assign req1_op    = r_op[1];
  assign req1_a     = r_a[1];
  assign req1_b     = r_b[1];
  assign rsp1_ready = rsp_rdy[1];

  fpu_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rsp1_ready(rsp1_ready),
    .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_y(fpu_y),
    .fpu_out_valid(fpu_out_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Operation table: op -> {legal, one-hot opcode}
  function automatic logic [8:0] decode_ref(input logic [4:0] op);
    case (op)
      5'b10000: return {1'b1, 8'h01};
      5'b10001: return {1'b1, 8'h02};
      5'b10010: return {1'b1, 8'h04};
      5'b10011: return {1'b1, 8'h08};
      5'b11011: return {1'b1, 8'h10};
      5'b10110: return {1'b1, 8'h20};
      5'b10111: return {1'b1, 8'h40};
      5'b10101: return {1'b1, 8'h80};
      default:  return 9'h000;
    endcase
  endfunction

  // Stand-in FPU arithmetic: any operand/opcode mix-up changes the result.
  function automatic logic [31:0] fy(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b);
    return a ^ {b[15:0], b[31:16]} ^ {24'h0, opc};
  endfunction

  logic [4:0] legal_ops [8] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
                                5'b11011, 5'b10110, 5'b10111, 5'b10101};

  // ---------------- transaction-level reference model ----------------
  bit          m_act = 0, m_own = 0, m_legal = 0, m_to = 0, m_last = 1, m_err = 0;
  int          m_tacc = 0, m_thold = 0;
  logic [7:0]  m_opc = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  bit          hs [2] = '{0, 0};
  int          dut_grants [$];

  // FPU stub state
  bit          st_pend = 0, use_fix = 0;
  int          st_fire = 0, st_lat = 0;
  logic [31:0] st_y = '0, fix_y = '0;

  always @(negedge rstn) begin
    m_act = 0; m_last = 1; m_err = 0; hs[0] = 0; hs[1] = 0;
  end

  always @(negedge clk) begin : cmp
    int k, p;
    logic e_r0, e_r1, e_hold, e_v0, e_v1;
    logic [8:0] d;
    if (rstn) begin
      k = cyc;
      if (m_act && m_to && k >= m_thold) m_err = 1;
      e_r0   = !m_act && r_valid[0] && (!r_valid[1] || m_last);
      e_r1   = !m_act && r_valid[1] && (!r_valid[0] || !m_last);
      e_hold = m_act && k >= m_thold;
      e_v0   = e_hold && !m_own;
      e_v1   = e_hold && m_own;
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("busy", busy, m_act);
      chk("fpu_opcode", fpu_opcode, (m_act && k == m_tacc + 1 && m_legal) ? m_opc : 8'h00);
      chk("rsp0_valid", rsp0_valid, e_v0);
      chk("rsp1_valid", rsp1_valid, e_v1);
      chk("rsp0_data", rsp0_data, e_v0 ? m_res : 32'h0);
      chk("rsp1_data", rsp1_data, e_v1 ? m_res : 32'h0);
      chk("timeout_err", timeout_err, m_err);
      if (m_act && k == m_tacc + 1 && m_legal) begin
        chk("fpu_x1", fpu_x1, m_a);
        chk("fpu_x2", fpu_x2, m_b);
      end
      if (req0_valid && req0_ready) dut_grants.push_back(0);
      if (req1_valid && req1_ready) dut_grants.push_back(1);
      hs[0] = e_r0;
      hs[1] = e_r1;
      if (e_hold && rsp_rdy[m_own]) begin
        m_act  = 0;
        m_last = m_own;
      end else if (e_r0 || e_r1) begin
        p       = e_r1 ? 1 : 0;
        d       = decode_ref(r_op[p]);
        m_act   = 1;
        m_own   = (p == 1);
        m_tacc  = k;
        m_legal = d[8];
        m_opc   = d[7:0];
        m_a     = r_a[p];
        m_b     = r_b[p];
        st_lat  = r_lat[p];
        if (!m_legal) begin
          m_thold = k + 2; m_res = '0; m_to = 0;
        end else if (r_lat[p] != 0 && r_lat[p] <= TO) begin
          m_thold = k + 2 + r_lat[p]; m_res = use_fix ? fix_y : fy(m_opc, m_a, m_b); m_to = 0;
        end else begin
          m_thold = k + 2 + TO; m_res = '0; m_to = 1;
        end
      end
    end
  end

  // ---------------- FPU stub ----------------
  always @(negedge clk) begin
    if (rstn && fpu_opcode != 8'h00) begin
      st_pend = 1;
      st_fire = (st_lat == 0) ? 32'h7fffffff : cyc + st_lat;
      st_y    = use_fix ? fix_y : fy(fpu_opcode, fpu_x1, fpu_x2);
    end
  end

  initial begin
    fpu_out_valid = 1'b0;
    fpu_y         = '0;
    forever begin
      @(posedge clk); #1;
      if (st_pend && cyc == st_fire) begin
        fpu_out_valid = 1'b1; fpu_y = st_y; st_pend = 0;
      end else if (!st_pend && $urandom_range(0, 5) == 0) begin
        fpu_out_valid = 1'b1; fpu_y = $urandom;   // stray strobe outside WAIT
      end else begin
        fpu_out_valid = 1'b0; fpu_y = $urandom;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic new_req(input int p);
    r_valid[p] = 1'b1;
    r_op[p]    = ($urandom_range(0, 4) != 0) ? legal_ops[$urandom_range(0, 7)] : 5'($urandom);
    r_a[p]     = $urandom;
    r_b[p]     = $urandom;
    r_lat[p]   = $urandom_range(0, 9);
  endtask

  task automatic drain();
    rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      for (int p = 0; p < 2; p++) if (hs[p]) r_valid[p] = 1'b0;
      #1;
      if (!r_valid[0] && !r_valid[1] && !busy) break;
    end
    chk("drain idle", busy, 0);
  endtask

  task automatic do_reset();
    #3 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
  endtask

  task automatic lat_case(input int lat, input logic [31:0] exp_data, input logic exp_err);
    step();
    r_valid[0] = 1'b1; r_op[0] = 5'b10010; r_a[0] = 32'h12345678; r_b[0] = 32'h9ABCDEF0;
    r_lat[0] = lat; rsp_rdy[0] = 1'b0;
    step(); r_valid[0] = 1'b0;
    repeat (8) step();
    #1;
    chk("lat rsp T+9", rsp0_valid, 0);
    chk("lat err T+9", timeout_err, 0);
    step(); #1;
    chk("lat rsp T+10", rsp0_valid, 1);
    chk("lat data T+10", rsp0_data, exp_data);
    chk("lat err T+10", timeout_err, exp_err);
    drain();
  endtask

  task automatic reset_mid(input int n);
    step();
    r_valid[0] = 1'b1; r_op[0] = 5'b10000; r_a[0] = $urandom; r_b[0] = $urandom;
    r_lat[0] = 0; rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    #1 chk("rm accept", req0_ready, 1);
    step(); r_valid[0] = 1'b0;
    repeat (n - 1) step();
    #1 chk("rm busy before", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rm opcode", fpu_opcode, 8'h00);
    chk("rm busy", busy, 0);
    chk("rm rsp0_valid", rsp0_valid, 0);
    chk("rm timeout_err", timeout_err, 0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    st_pend = 1; st_fire = cyc + 2; st_y = 32'hDEADBEEF;   // late result after reset
    repeat (5) step();
    #1 chk("rm idle after late strobe", busy, 0);
    step();
    r_valid[0] = 1'b1; r_op[0] = 5'b10001; r_lat[0] = 1;
    r_valid[1] = 1'b1; r_op[1] = 5'b10010; r_lat[1] = 1;
    #1;
    chk("rm grant port0", req0_ready, 1);
    chk("rm no grant port1", req1_ready, 0);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    for (int p = 0; p < 2; p++) begin
      r_valid[p] = 1'b0; r_op[p] = '0; r_a[p] = '0; r_b[p] = '0; r_lat[p] = 1; rsp_rdy[p] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    step(); #1;
    chk("reset busy", busy, 0);
    chk("reset opcode", fpu_opcode, 8'h00);
    chk("reset timeout_err", timeout_err, 0);
    chk("reset rsp0_valid", rsp0_valid, 0);

    // Single FADD on port 0 with a 3-cycle FPU, then a 10-cycle HOLD stall.
    step(); t0 = cyc;
    use_fix = 1; fix_y = 32'h40400000;
    r_valid[0] = 1'b1; r_op[0] = 5'b10000; r_a[0] = 32'h3F800000; r_b[0] = 32'h40000000;
    r_lat[0] = 3;
    #1 chk("d1 req0_ready", req0_ready, 1);
    step(); r_valid[0] = 1'b0;
    #1 chk("d1 pulse T+1", fpu_opcode, 8'h01);
    step(); #1 chk("d1 pulse T+2", fpu_opcode, 8'h00);
    step(); step(); #1 chk("d1 rsp0 T+4", rsp0_valid, 0);
    step(); #1;
    chk("d1 rsp0 T+5", rsp0_valid, 1);
    chk("d1 data T+5", rsp0_data, 32'h40400000);
    chk("d1 rsp1 T+5", rsp1_valid, 0);
    chk("d1 elapsed", cyc - t0, 5);
    step();
    r_valid[1] = 1'b1; r_op[1] = 5'b10011; r_a[1] = $urandom; r_b[1] = $urandom; r_lat[1] = 2;
    #1 chk("hold req1_ready", req1_ready, 0);
    repeat (8) begin
      step(); #1;
      chk("hold rsp0_valid", rsp0_valid, 1);
      chk("hold rsp0_data", rsp0_data, 32'h40400000);
      chk("hold req1_ready", req1_ready, 0);
    end
    step(); rsp_rdy[0] = 1'b1;
    #1 chk("hold release same cycle", req1_ready, 0);
    step(); rsp_rdy[0] = 1'b0;
    #1 chk("accept after release", req1_ready, 1);
    drain();
    use_fix = 0;

    // Both ports requesting continuously from reset: strict alternation.
    do_reset();
    dut_grants.delete();
    step();
    r_valid[0] = 1'b1; r_op[0] = 5'b10001; r_lat[0] = 1;
    r_valid[1] = 1'b1; r_op[1] = 5'b10010; r_lat[1] = 1;
    rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1;
    for (int i = 0; i < 200 && dut_grants.size() < 6; i++) step();
    chk("alt grant count", dut_grants.size(), 6);
    for (int i = 0; i < dut_grants.size() && i < 6; i++) chk("alt order", dut_grants[i], i % 2);
    drain();

    // Illegal op on port 1.
    step();
    r_valid[1] = 1'b1; r_op[1] = 5'b11111; r_lat[1] = 3; rsp_rdy[1] = 1'b0;
    #1 chk("ill req1_ready", req1_ready, 1);
    step(); r_valid[1] = 1'b0;
    #1 chk("ill no pulse", fpu_opcode, 8'h00);
    step(); #1;
    chk("ill rsp1_valid T+2", rsp1_valid, 1);
    chk("ill rsp1_data", rsp1_data, 32'h0);
    chk("ill timeout_err", timeout_err, 0);
    drain();

    // Result on the last allowed WAIT cycle, then a real timeout.
    lat_case(8, 32'hCCC4CCC0, 1'b0);
    lat_case(0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (hs[p]) r_valid[p] = 1'b0;
        if (!r_valid[p] && $urandom_range(0, 2) == 0) new_req(p);
        rsp_rdy[p] = 1'($urandom_range(0, 1));
      end
    end
    drain();
    #1 chk("timeout_err sticky", timeout_err, 1);

    // Reset during WAIT and during ISSUE.
    reset_mid(3);
    reset_mid(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
